pipelined_adder_nbit: RTL and testbench
=======================================

Name: pipelined_adder_nbit

Overview:
- Parametrised N-bit unsigned adder with carry-in. The carry chain is split into STAGES equal chunks, with one pipeline register per chunk.
- Uses a valid/ready handshake on both input and output, so it can sit between streaming datapath blocks. It replaces single-cycle combinational adders on paths too wide for one cycle.
- Overflow is the carry out of the MSB.

Parameters:
- WIDTH, 32: operand and sum width in bits. Must be >= 2.
- STAGES, 4: number of pipeline stages, equal to the number of chunks. 1 <= STAGES <= WIDTH, and WIDTH % STAGES == 0; otherwise raise an elaboration-time $error.

Ports:
- clk  input  1  system clock, rising edge
- n_rst  input  1  asynchronous active-low reset
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- carry_in  input  1  carry into bit 0
- in_valid  input  1  a, b and carry_in are valid this cycle
- in_ready  output  1  block accepts the input this cycle
- sum  output  WIDTH  registered result
- overflow  output  1  carry out of bit WIDTH-1 for this result
- out_valid  output  1  sum and overflow are valid
- out_ready  input  1  downstream accepts the result

Behaviour:
- Chunk width: CHUNK = WIDTH/STAGES. Stage k computes bits [k*CHUNK +: CHUNK] using the carry registered by stage k-1; stage 0 uses carry_in.
- Skew: each stage register holds:
  - the partial sum computed so far (lower chunks)
  - the not-yet-added upper chunks of a and b
  - the chunk carry
  - a valid bit v[k]
- Transfers:
  - Input is accepted when in_valid && in_ready.
  - Output is taken when out_valid && out_ready.
- Stall rule: stage k advances when v[k]==0 or stage k+1 advances. The last stage advances when out_ready==1. Each stage loads whenever it advances, capturing the previous stage's result or the input bubble.
- in_ready = !v[0] || stage 0 advances. This ready path is combinational through the chain, with no buffer bubbles at full throughput.
- Throughput and latency:
  - Throughput is 1 result per cycle when out_ready is held high.
  - Latency is exactly STAGES cycles from acceptance to out_valid, with no stalls.
  - STAGES==1 degenerates to a single registered adder with 1-cycle latency.
- Outputs:
  - out_valid = v[STAGES-1].
  - sum and overflow come directly from the last stage register.
  - sum and overflow hold stable while out_valid && !out_ready.
- Arithmetic: sum = (a + b + carry_in) mod 2^WIDTH. overflow = bit WIDTH of the full sum (unsigned carry-out, not signed overflow).
- Wrap example: a = all ones, b = 0, carry_in = 1 gives sum = 0 and overflow = 1.
- Simultaneous accept and emit in one cycle on a full pipeline is legal. Occupancy is unchanged and no data is lost or duplicated.
- Reset:
  - Asserting n_rst low at any time asynchronously clears all v[k], sum, overflow, and all internal registers to 0.
  - in_ready is 1 when the pipeline is empty.
  - In-flight data is discarded.
  - The first acceptance can occur on the first rising edge after n_rst deasserts.
- Protocol assertions (simulation only): on an accepted input, a, b and carry_in must be 0/1 (no X/Z), else $error.
- Output stability while stalled is a bench check, not an RTL requirement.

Optional Feature:
- Macro: ADDER_SATURATE_EN.
- Defined: when the computed carry-out is 1, sum is forced to all ones and overflow is still 1. Saturation is applied in the last stage only, so latency is unchanged.
- Undefined: sum wraps modulo 2^WIDTH as above. No extra logic.

Decomposition:
- Package adder_pkg holds:
  - the default constants ADDER_DEFAULT_WIDTH = 32 and ADDER_DEFAULT_STAGES = 4
  - a function chunk_width(width, stages), used in the elaboration check.
- Sub-module adder_chunk #(CHUNK) handles one stage's combinational add: a/b chunk plus carry in gives a sum chunk and carry out.
- The top generates STAGES instances of adder_chunk plus the stage registers and valid/stall logic.

Test Plan (WIDTH=16, STAGES=4 unless noted):
- Single transfer: a=16'h1234, b=16'h4321, cin=0, out_ready=1. Expect out_valid exactly 4 cycles after acceptance, sum=16'h5555, overflow=0.
- Carry ripple across chunks: a=16'hFFFF, b=16'h0000, cin=1. Expect sum=16'h0000, overflow=1 (saturate build: sum=16'hFFFF, overflow=1).
- Back-to-back stream: 100 random operand sets, in_valid and out_ready held high. Expect one result per cycle, in order, matching a golden model.
- Backpressure: fill the pipeline, hold out_ready=0 for 5 cycles. Expect:
  - in_ready drops once all 4 stages are valid
  - sum and overflow hold stable
  - no loss or duplication after release
- Random handshake: random in_valid/out_ready, 1000 transactions. Expect scoreboard match and an accepted count equal to the emitted count.
- Reset mid-stream: drop n_rst with 3 entries in flight. Expect out_valid=0, sum=0, overflow=0 immediately, in_ready=1, and no stale result emitted after release. Repeat with STAGES=1 and STAGES=16.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared constants and helpers for the pipelined N-bit adder.
// Optional saturation is enabled with ADDER_SATURATE_EN.
package adder_pkg;

   localparam int ADDER_DEFAULT_WIDTH  = 32;
   localparam int ADDER_DEFAULT_STAGES = 4;

   function automatic int chunk_width(input int width, input int stages);
      return (stages > 0) ? width / stages : 0;
   endfunction

endpackage

// File: rtl/adder_chunk.sv
// One chunk of the carry chain: CHUNK-bit add with carry in/out.
// Purely combinational; the stage register lives in the top.
module adder_chunk #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             carry_in,
   output logic [CHUNK-1:0] sum,
   output logic             carry_out
);

   assign {carry_out, sum} = {1'b0, a} + {1'b0, b}
                           + (CHUNK+1)'(carry_in);

endmodule

// File: rtl/pipelined_adder_nbit.sv
// Pipelined N-bit adder, STAGES chunks, valid/ready on both sides.
// Define ADDER_SATURATE_EN to clamp the sum to all ones on carry-out.
module pipelined_adder_nbit
   import adder_pkg::*;
#(
   parameter int WIDTH  = ADDER_DEFAULT_WIDTH,
   parameter int STAGES = ADDER_DEFAULT_STAGES
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carry_in,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] sum,
   output logic             overflow,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int CHUNK = chunk_width(WIDTH, STAGES);

   if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH ||
       CHUNK * STAGES != WIDTH) begin : g_bad_cfg
      $error("pipelined_adder_nbit: illegal WIDTH/STAGES");
   end

   logic [STAGES-1:0][WIDTH-1:0] ra_q;
   logic [STAGES-1:0][WIDTH-1:0] rb_q;
   logic [STAGES-1:0][WIDTH-1:0] ps_q;
   logic [STAGES-1:0]            c_q;
   logic [STAGES-1:0]            v_q;
   logic [STAGES-1:0]            adv;

   // Ready ripples back from the output through every stage.
   always_comb begin : stall_chain
      logic go;
      go = !v_q[STAGES-1] || out_ready;
      adv = '0;
      adv[STAGES-1] = go;
      for (int k = STAGES - 2; k >= 0; k--) begin
         go = !v_q[k] || go;
         adv[k] = go;
      end
   end

   assign in_ready  = adv[0];
   assign out_valid = v_q[STAGES-1];
   assign sum       = ps_q[STAGES-1];
   assign overflow  = c_q[STAGES-1];

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [WIDTH-1:0] sa;
      logic [WIDTH-1:0] sb;
      logic [WIDTH-1:0] sp;
      logic [WIDTH-1:0] np;
      logic [CHUNK-1:0] cs;
      logic             sc;
      logic             co;
      logic             vin;

      if (k == 0) begin : g_first
         assign sa  = a;
         assign sb  = b;
         assign sp  = '0;
         assign sc  = carry_in;
         assign vin = in_valid;
      end else begin : g_next
         assign sa  = ra_q[k-1];
         assign sb  = rb_q[k-1];
         assign sp  = ps_q[k-1];
         assign sc  = c_q[k-1];
         assign vin = v_q[k-1];
      end

      adder_chunk #(.CHUNK(CHUNK)) u_chunk (
         .a         (sa[k*CHUNK +: CHUNK]),
         .b         (sb[k*CHUNK +: CHUNK]),
         .carry_in  (sc),
         .sum       (cs),
         .carry_out (co)
      );

      always_comb begin
         np = sp;
         np[k*CHUNK +: CHUNK] = cs;
`ifdef ADDER_SATURATE_EN
         if (k == STAGES - 1 && co) np = '1;
`endif
      end

      always_ff @(posedge clk or negedge n_rst) begin
         if (!n_rst) begin
            v_q[k]  <= 1'b0;
            ra_q[k] <= '0;
            rb_q[k] <= '0;
            ps_q[k] <= '0;
            c_q[k]  <= 1'b0;
         end else if (adv[k]) begin
            v_q[k]  <= vin;
            ra_q[k] <= sa;
            rb_q[k] <= sb;
            ps_q[k] <= np;
            c_q[k]  <= co;
         end
      end
   end

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (n_rst && in_valid && in_ready)
         assert (!$isunknown({a, b, carry_in}))
         else $error("pipelined_adder_nbit: X/Z on accepted input");
   end
`endif

endmodule

// File: tb/tb_pipelined_adder_nbit.sv
// Scoreboard bench: three adders (STAGES 4, 1, 16) on shared stimulus.
// Each DUT has its own expected-result queue and monitor.
module tb_pipelined_adder_nbit;

   logic        clk = 1'b0;
   logic        n_rst;
   logic [15:0] a;
   logic [15:0] b;
   logic        cin;
   logic        in_valid;
   logic        out_ready;

   logic        rdy   [3];
   logic [15:0] sum_w [3];
   logic        ov_w  [3];
   logic        ovld  [3];
   int          acc   [3];
   int          emi   [3];

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask

   function automatic logic [16:0] model(input logic [15:0] x,
                                         input logic [15:0] y,
                                         input logic c);
      logic [16:0] r;
      r = 17'(x) + 17'(y) + 17'(c);
`ifdef ADDER_SATURATE_EN
      if (r[16]) r[15:0] = 16'hFFFF;
`endif
      return r;
   endfunction

   for (genvar i = 0; i < 3; i++) begin : g_dut
      localparam int STG = (i == 0) ? 4 : ((i == 1) ? 1 : 16);
      logic [16:0] q[$];
      logic [16:0] e;

      pipelined_adder_nbit #(.WIDTH(16), .STAGES(STG)) u_dut (
         .clk       (clk),
         .n_rst     (n_rst),
         .a         (a),
         .b         (b),
         .carry_in  (cin),
         .in_valid  (in_valid),
         .in_ready  (rdy[i]),
         .sum       (sum_w[i]),
         .overflow  (ov_w[i]),
         .out_valid (ovld[i]),
         .out_ready (out_ready)
      );

      always @(negedge clk) begin
         if (n_rst) begin
            if (in_valid && rdy[i]) begin
               q.push_back(model(a, b, cin));
               acc[i]++;
            end
            if (ovld[i] && out_ready) begin
               emi[i]++;
               if (q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL sb%0d unexpected output got=%h want=none",
                           i, {ov_w[i], sum_w[i]});
               end else begin
                  e = q.pop_front();
                  check($sformatf("sb%0d", i),
                        32'({ov_w[i], sum_w[i]}), 32'(e));
               end
            end
         end
      end

      always @(negedge n_rst) q.delete();
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (24) step();
   endtask

   task automatic send_one(input logic [15:0] x, input logic [15:0] y,
                           input logic c, output int lat);
      a = x; b = y; cin = c;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      lat = 1;
      while (!ovld[0] && lat < 20) begin
         step();
         lat++;
      end
   endtask

   initial begin
      int lat;
      int stalls;
      int cyc;
      int target;
      logic [15:0] held_sum;
      logic        held_ov;
      int snap [3];

      for (int i = 0; i < 3; i++) begin
         acc[i] = 0;
         emi[i] = 0;
      end
      n_rst = 1'b0; a = '0; b = '0; cin = 1'b0;
      in_valid = 1'b0; out_ready = 1'b0;
      repeat (3) step();
      for (int i = 0; i < 3; i++) begin
         check($sformatf("rst_valid%0d", i), 32'(ovld[i]), 0);
         check($sformatf("rst_sum%0d", i), 32'(sum_w[i]), 0);
         check($sformatf("rst_ready%0d", i), 32'(rdy[i]), 1);
      end
      n_rst = 1'b1;

      send_one(16'h1234, 16'h4321, 1'b0, lat);
      check("single_latency", 32'(lat), 4);
      check("single_sum", 32'(sum_w[0]), 32'h5555);
      check("single_ovf", 32'(ov_w[0]), 0);
      drain();

      send_one(16'hFFFF, 16'h0000, 1'b1, lat);
      check("ripple_latency", 32'(lat), 4);
`ifdef ADDER_SATURATE_EN
      check("ripple_sum", 32'(sum_w[0]), 32'hFFFF);
`else
      check("ripple_sum", 32'(sum_w[0]), 32'h0000);
`endif
      check("ripple_ovf", 32'(ov_w[0]), 1);
      drain();

      stalls = 0;
      in_valid = 1'b1; out_ready = 1'b1;
      for (int n = 0; n < 100; n++) begin
         a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
         if (!rdy[0] || !rdy[2]) stalls++;
         step();
      end
      check("stream_stalls", 32'(stalls), 0);
      check("stream_valid", 32'(ovld[0]), 1);
      drain();

      in_valid = 1'b1; out_ready = 1'b0;
      for (int n = 0; n < 8; n++) begin
         a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
         step();
      end
      check("bp_ready_low", 32'(rdy[0]), 0);
      check("bp_valid", 32'(ovld[0]), 1);
      held_sum = sum_w[0];
      held_ov  = ov_w[0];
      for (int n = 0; n < 5; n++) begin
         step();
         check("bp_hold_sum", 32'(sum_w[0]), 32'(held_sum));
         check("bp_hold_ovf", 32'(ov_w[0]), 32'(held_ov));
      end
      drain();

      target = acc[0] + 1000;
      cyc = 0;
      while (acc[0] < target && cyc < 20000) begin
         a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
         in_valid  = 1'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         step();
         cyc++;
      end
      check("rand_timeout", 32'(cyc < 20000), 1);
      drain();
      for (int i = 0; i < 3; i++)
         check($sformatf("acc_eq_emi%0d", i), 32'(emi[i]), 32'(acc[i]));

      in_valid = 1'b1; out_ready = 1'b0;
      for (int n = 0; n < 3; n++) begin
         a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
         step();
      end
      in_valid = 1'b0;
      #2;
      n_rst = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("mid_rst_valid%0d", i), 32'(ovld[i]), 0);
         check($sformatf("mid_rst_sum%0d", i), 32'(sum_w[i]), 0);
         check($sformatf("mid_rst_ovf%0d", i), 32'(ov_w[i]), 0);
         check($sformatf("mid_rst_ready%0d", i), 32'(rdy[i]), 1);
      end
      step();
      n_rst = 1'b1;
      for (int i = 0; i < 3; i++) snap[i] = emi[i];
      out_ready = 1'b1;
      repeat (30) step();
      for (int i = 0; i < 3; i++)
         check($sformatf("no_stale%0d", i), 32'(emi[i]), 32'(snap[i]));

      send_one(16'h00FF, 16'h0001, 1'b0, lat);
      check("post_rst_latency", 32'(lat), 4);
      check("post_rst_sum", 32'(sum_w[0]), 32'h0100);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
